// File: rtl/frame_tx_scheduler.sv
// frame_tx_scheduler: FIFO-to-UART egress sequencer for the 16x16 pressure-sensor system.
// Every frame_done produces one packet: HDR0, HDR1, frame counter, FRAME_LEN payload bytes
// popped from the sample FIFO and, when FRAME_CHECKSUM_EN is defined, a mod-256 checksum byte.
// Optional feature macro: FRAME_CHECKSUM_EN (undefined: no checksum byte, no accumulator).
// Ports:
//   sys_clk, sys_rst          clock, asynchronous active-high reset
//   frame_done                one-cycle pulse, a full frame is in the FIFO
//   fifo_empty, fifo_rd_data  FIFO status and read data (valid one cycle after fifo_rd_en)
//   fifo_rd_en                FIFO pop strobe
//   uart_busy                 UART transmitter busy
//   uart_en, uart_din         transmit-start strobe and byte to send
//   tx_active                 packet in progress
//   frame_cnt                 frames fully transmitted (wraps)
//   transmission_error        one-cycle pulse on busy timeout, FIFO underrun or frame overrun
module frame_tx_scheduler #(
    parameter int unsigned FRAME_LEN        = 256,
    parameter logic [7:0]  HDR0             = 8'hAA,
    parameter logic [7:0]  HDR1             = 8'h55,
    parameter int unsigned BUSY_TIMEOUT     = 16,
    parameter int unsigned UNDERRUN_TIMEOUT = 1024
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       frame_done,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rd_data,
    output logic       fifo_rd_en,
    input  logic       uart_busy,
    output logic       uart_en,
    output logic [7:0] uart_din,
    output logic       tx_active,
    output logic [7:0] frame_cnt,
    output logic       transmission_error
);

    localparam int unsigned LEN_W = 9;
    localparam int unsigned BTO_W = $clog2(BUSY_TIMEOUT) + 1;
    localparam int unsigned UTO_W = $clog2(UNDERRUN_TIMEOUT) + 1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_SEND, ST_WAIT_HI, ST_WAIT_LO, ST_POP, ST_POP_WAIT, ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        SEL_HDR0, SEL_HDR1, SEL_CNT, SEL_PAY, SEL_CSUM
    } sel_t;

    state_t             state_q, state_d;
    sel_t               sel_q, sel_d;
    logic               pending_q, pending_d;
    logic               tx_active_q, tx_active_d;
    logic               uart_en_q, uart_en_d;
    logic [7:0]         uart_din_q, uart_din_d;
    logic               fifo_rd_en_q, fifo_rd_en_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;
    logic               err_q, err_d;
    logic [LEN_W-1:0]   pay_cnt_q, pay_cnt_d;
    logic [BTO_W-1:0]   bto_q, bto_d;
    logic [UTO_W-1:0]   uto_q, uto_d;
    logic               rd_phase_q, rd_phase_d;
    logic               ok_q, ok_d;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        pending_d    = pending_q;
        tx_active_d  = tx_active_q;
        uart_en_d    = 1'b0;
        uart_din_d   = uart_din_q;
        fifo_rd_en_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        err_d        = 1'b0;
        pay_cnt_d    = pay_cnt_q;
        bto_d        = bto_q;
        uto_d        = uto_q;
        rd_phase_d   = rd_phase_q;
        ok_d         = ok_q;
`ifdef FRAME_CHECKSUM_EN
        csum_d       = csum_q;
`endif

        // One frame may queue behind the active one; a further one is dropped and flagged
        if (frame_done && tx_active_q) begin
            if (pending_q) err_d = 1'b1;
            else           pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_done || pending_q) begin
                    // A fresh frame_done arriving while consuming pending stays queued
                    pending_d   = pending_q && frame_done;
                    tx_active_d = 1'b1;
                    sel_d       = SEL_HDR0;
                    pay_cnt_d   = '0;
                    uto_d       = '0;
                    ok_d        = 1'b0;
`ifdef FRAME_CHECKSUM_EN
                    csum_d      = 8'h00;
`endif
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                case (sel_q)
                    SEL_HDR0: uart_din_d = HDR0;
                    SEL_HDR1: uart_din_d = HDR1;
                    SEL_CNT:  uart_din_d = frame_cnt_q;
`ifdef FRAME_CHECKSUM_EN
                    SEL_CSUM: uart_din_d = csum_q;
`endif
                    default:  uart_din_d = uart_din_q;
                endcase
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (!uart_busy) begin
                    uart_en_d = 1'b1;
                    bto_d     = '0;
                    state_d   = ST_WAIT_HI;
`ifdef FRAME_CHECKSUM_EN
                    if (sel_q != SEL_CSUM) csum_d = csum_q + uart_din_q;
`endif
                end
            end
            ST_WAIT_HI: begin
                if (uart_busy) begin
                    state_d = ST_WAIT_LO;
                end else if (bto_q == BTO_W'(BUSY_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    bto_d = bto_q + BTO_W'(1);
                end
            end
            ST_WAIT_LO: begin
                if (!uart_busy) begin
                    case (sel_q)
                        SEL_HDR0: begin sel_d = SEL_HDR1; state_d = ST_LOAD; end
                        SEL_HDR1: begin sel_d = SEL_CNT;  state_d = ST_LOAD; end
                        SEL_CNT:  begin sel_d = SEL_PAY;  state_d = ST_POP;  end
                        SEL_PAY: begin
                            if (pay_cnt_q == LEN_W'(FRAME_LEN)) begin
`ifdef FRAME_CHECKSUM_EN
                                sel_d   = SEL_CSUM;
                                state_d = ST_LOAD;
`else
                                ok_d    = 1'b1;
                                state_d = ST_DONE;
`endif
                            end else begin
                                state_d = ST_POP;
                            end
                        end
                        default: begin ok_d = 1'b1; state_d = ST_DONE; end
                    endcase
                end
            end
            ST_POP: begin
                // Pop only on a non-empty FIFO; count consecutive empty cycles otherwise
                if (!fifo_empty) begin
                    fifo_rd_en_d = 1'b1;
                    uto_d        = '0;
                    rd_phase_d   = 1'b0;
                    state_d      = ST_POP_WAIT;
                end else if (uto_q == UTO_W'(UNDERRUN_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    uto_d = uto_q + UTO_W'(1);
                end
            end
            ST_POP_WAIT: begin
                // First cycle is the strobe itself; data is valid the cycle after
                if (!rd_phase_q) begin
                    rd_phase_d = 1'b1;
                end else begin
                    uart_din_d = fifo_rd_data;
                    pay_cnt_d  = pay_cnt_q + LEN_W'(1);
                    state_d    = ST_SEND;
                end
            end
            ST_DONE: begin
                if (ok_q) frame_cnt_d = frame_cnt_q + 8'd1;
                tx_active_d = 1'b0;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= ST_IDLE;
            sel_q        <= SEL_HDR0;
            pending_q    <= 1'b0;
            tx_active_q  <= 1'b0;
            uart_en_q    <= 1'b0;
            uart_din_q   <= 8'h00;
            fifo_rd_en_q <= 1'b0;
            frame_cnt_q  <= 8'h00;
            err_q        <= 1'b0;
            pay_cnt_q    <= '0;
            bto_q        <= '0;
            uto_q        <= '0;
            rd_phase_q   <= 1'b0;
            ok_q         <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            csum_q       <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            pending_q    <= pending_d;
            tx_active_q  <= tx_active_d;
            uart_en_q    <= uart_en_d;
            uart_din_q   <= uart_din_d;
            fifo_rd_en_q <= fifo_rd_en_d;
            frame_cnt_q  <= frame_cnt_d;
            err_q        <= err_d;
            pay_cnt_q    <= pay_cnt_d;
            bto_q        <= bto_d;
            uto_q        <= uto_d;
            rd_phase_q   <= rd_phase_d;
            ok_q         <= ok_d;
`ifdef FRAME_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign fifo_rd_en         = fifo_rd_en_q;
    assign uart_en            = uart_en_q;
    assign uart_din           = uart_din_q;
    assign tx_active          = tx_active_q;
    assign frame_cnt          = frame_cnt_q;
    assign transmission_error = err_q;

endmodule
